// File: rtl/result_packer.sv
// result_packer: packs a stream of 2-bit result samples (with a per-sample
// status flag) into words of SAMPLES slots. Sample 0 lands in the LSBs.
// A word closes when it is full or on flush, then holds until downstream
// takes it. Optional build macro: PACKER_PARITY_EN adds out_parity, the XOR
// of all out_data bits, captured together with the word.
module result_packer #(
    parameter  int SAMPLES = 4,
    localparam int CW      = $clog2(SAMPLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_data,
    input  logic                 in_flag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*SAMPLES-1:0] out_data,
    output logic [CW-1:0]        out_count,
`ifdef PACKER_PARITY_EN
    output logic                 out_parity,
`endif
    output logic                 out_flag
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(SAMPLES - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        idx_q, idx_d;
    logic [2*SAMPLES-1:0] data_q, data_d;
    logic                 flag_q, flag_d;
    logic [CW-1:0]        count_q, count_d;
`ifdef PACKER_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // One-hot decode of the slot the next accepted sample is written into.
    logic [SAMPLES-1:0] slot_hit;
    logic [2*SAMPLES-1:0] slot_data;

    genvar gi;
    generate
        for (gi = 0; gi < SAMPLES; gi++) begin : g_slot
            assign slot_hit[gi] = (idx_q == CW'(gi));
            assign slot_data[2*gi +: 2] = slot_hit[gi] ? in_data : data_q[2*gi +: 2];
        end
    endgenerate

    logic accept;
    assign accept = (state_q == FILL) && in_valid;

    // Next-state and datapath: fill slots, close the word when full or flushed,
    // release and clear everything once the held word is taken.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        flag_d   = flag_q;
        count_d  = count_q;
`ifdef PACKER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            FILL: begin
                if (accept) begin
                    data_d = slot_data;
                    flag_d = flag_q | in_flag;
                    idx_d  = idx_q + CW'(1);
                    if ((idx_q == LAST_IDX) || flush) begin
                        state_d = HOLD;
                        count_d = idx_q + CW'(1);
                    end
                end else if (flush && (idx_q != '0)) begin
                    // Flush of a partial word; unfilled slots are already 0.
                    state_d = HOLD;
                    count_d = idx_q;
                end
`ifdef PACKER_PARITY_EN
                if (state_d == HOLD) begin
                    parity_d = ^data_d;
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    state_d  = FILL;
                    idx_d    = '0;
                    data_d   = '0;
                    flag_d   = 1'b0;
                    count_d  = '0;
`ifdef PACKER_PARITY_EN
                    parity_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and word registers; reset drops any partial or held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            idx_q    <= '0;
            data_q   <= '0;
            flag_q   <= 1'b0;
            count_q  <= '0;
`ifdef PACKER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            flag_q   <= flag_d;
            count_q  <= count_d;
`ifdef PACKER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign in_ready   = (state_q == FILL);
    assign out_valid  = (state_q == HOLD);
    assign out_data   = data_q;
    assign out_count  = count_q;
    assign out_flag   = flag_q;
`ifdef PACKER_PARITY_EN
    assign out_parity = parity_q;
`endif

endmodule

// File: doc/result_packer.md
RESULT_PACKER -- requirements
Module: result_packer

Interface
REQ-001 SHALL have parameter SAMPLES, default 4, giving the number of 2-bit samples per packed word; legal range 2..16.
REQ-002 SHALL have derived localparam CW = $clog2(SAMPLES+1), the width of the sample-count field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream sample present.
REQ-006 SHALL have port in_ready, output, 1 bit: the packer accepts a sample this cycle.
REQ-007 SHALL have port in_data, input, 2 bits: the 2-bit result sample (AND-stage output).
REQ-008 SHALL have port in_flag, input, 1 bit: the per-sample status bit (OR-of-ANDs stage output).
REQ-009 SHALL have port flush, input, 1 bit: close the current partial word.
REQ-010 SHALL have port out_valid, output, 1 bit: packed word available.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the word.
REQ-012 SHALL have port out_data, output, 2*SAMPLES bits: the packed samples.
REQ-013 SHALL have port out_count, output, CW bits: the number of valid samples in out_data.
REQ-014 SHALL have port out_flag, output, 1 bit: OR of in_flag over all samples in the word.
REQ-015 SHALL have port out_parity, output, 1 bit: present only when PACKER_PARITY_EN is defined.

Function
REQ-016 SHALL implement a two-state FSM, FILL and HOLD.
REQ-017 SHALL, in FILL, drive in_ready=1 and out_valid=0; in HOLD, drive in_ready=0 and out_valid=1.
REQ-018 SHALL accept a sample on the cycle in_valid&&in_ready is true, and write it to slot idx, bits [2*idx+1:2*idx], so sample 0 sits in the LSBs.
REQ-019 SHALL increment idx by 1 per accepted sample, and OR in_flag into the flag accumulator on each accept.
REQ-020 SHALL, on accepting the sample at idx==SAMPLES-1, go to HOLD on the next cycle with out_count=SAMPLES; fill latency is SAMPLES accepts and out_valid rises the cycle after the last accept.
REQ-021 SHALL, when flush=1 in FILL with idx>0 and no accept, go to HOLD with out_count=idx and unused slots reading 0.
REQ-022 SHALL, when flush=1 coincides with an accept, include that sample, go to HOLD with out_count=idx+1, and wrap to a full word if idx+1==SAMPLES.
REQ-023 SHALL ignore flush in FILL when idx==0 and no accept occurs (no empty words emitted), and SHALL ignore flush in HOLD.
REQ-024 SHALL hold out_data, out_count, out_flag and out_parity stable throughout HOLD until out_valid&&out_ready.
REQ-025 SHALL, on out_ready in HOLD, return to FILL on the next cycle with idx=0, data cleared to 0 and flag accumulator cleared to 0; the next sample can be accepted in that FILL cycle.
REQ-026 SHALL ignore in_data and in_flag whenever in_ready=0; upstream holds its sample until accepted.
REQ-027 SHALL give a sustained full-rate throughput of one word per SAMPLES+1 cycles.

Reset
REQ-028 SHALL, when rst_n=0 (asynchronous), immediately force state=FILL, idx=0, out_data=0, out_count=0, out_flag=0, out_parity=0, out_valid=0 and in_ready=1.
REQ-029 SHALL discard any partial or held word when reset is asserted mid-operation; nothing is emitted for it after release.
REQ-030 SHALL leave the first accept possible on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL use the macro PACKER_PARITY_EN: when defined, it adds port out_parity, equal to the XOR of all out_data bits and registered together with out_data entering HOLD.
REQ-032 SHALL, when PACKER_PARITY_EN is undefined, have no out_parity port and no parity logic; all other behaviour is identical.

Verification
REQ-033 SHALL cover full fill: SAMPLES=4, accept 2'b01,2'b10,2'b11,2'b00 with flags 0,0,1,0, out_ready=1 -> out_data=8'h39, out_count=4, out_flag=1, out_valid for 1 cycle.
REQ-034 SHALL cover backpressure: a full word with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0 for all 5 cycles, no sample lost after release.
REQ-035 SHALL cover partial flush: accept 2'b11,2'b10 then flush -> out_data=8'h0B, out_count=2; flush at idx=0 -> no word emitted.
REQ-036 SHALL cover simultaneous flush and accept: flush with the 3rd sample 2'b01 after 2'b11,2'b11 -> out_count=3, out_data=8'h1F.
REQ-037 SHALL cover reset mid-fill: rst_n low after 2 accepts -> outputs 0 at once, and the next 4 accepts form a fresh word with out_count=4.
REQ-038 SHALL cover parity: with PACKER_PARITY_EN defined, word 8'h39 -> out_parity=0 and word 8'h0B -> out_parity=1.
